// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 2**SEL_W-to-1 mux: steps the select lines through every
// channel, holds each for DWELL cycles, samples the mux output on the final
// dwell cycle and hands the assembled frame downstream on a valid/ready pair.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; sel parked at 0, no frame on offer
// SCAN  | walking sel through channels, sampling y at end of each dwell
// DONE  | frame_valid high, frame/sel frozen until out_ready
module mux_scan_sequencer #(
    parameter int SEL_W = 2,
    parameter int DWELL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    continuous,
    input  logic                    y,
    output logic [SEL_W-1:0]        sel,
    output logic [(2**SEL_W)-1:0]   frame,
    output logic                    frame_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int NUM_CH = 2**SEL_W;
    localparam logic [7:0]       CNT_LAST = 8'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic [SEL_W-1:0]    sel_q;
    logic [NUM_CH-1:0]   cap_q;
    logic [NUM_CH-1:0]   cap_d;
    logic [NUM_CH-1:0]   frame_q;
    logic                valid_q;

    // Shadow capture with the current channel's bit replaced by live y; used
    // both for the per-channel update and for the final frame on the last channel.
    always_comb begin
        cap_d        = cap_q;
        cap_d[sel_q] = y;
    end

    // Sequencer FSM; all outputs except busy are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            cap_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sel_q   <= '0;
                    valid_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_SCAN;
                        cnt_q   <= '0;
                        cap_q   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        cap_q <= cap_d;
                        if (sel_q == SEL_LAST) begin
                            frame_q <= cap_d;
                            valid_q <= 1'b1;
                            sel_q   <= '0;
                            state_q <= ST_DONE;
                        end else begin
                            sel_q <= sel_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    // valid_q is always set here, so out_ready alone completes the handshake
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        sel_q   <= '0;
                        if (continuous) begin
                            state_q <= ST_SCAN;
                            cnt_q   <= '0;
                            cap_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel         = sel_q;
    assign frame       = frame_q;
    assign frame_valid = valid_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
